// File: rtl/mem_mfc_responder.sv
// Memory-side responder for the MEMEn/MEMR_W/MFC 4-phase handshake.
// Captures a request, inserts WAIT_CYCLES wait states, performs the RAM access and raises MFC.
module mem_mfc_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEMEn,
  input  logic              MEMR_W,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              MFC,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_rd;
  logic [DATA_W-1:0] r_dout;
  logic              r_mfc;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_en;

  // Reset gates the write so a transaction interrupted by reset never lands.
  assign w_wr_en = reset && (r_state == S_ACCESS) && !r_rd;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr] <= r_data;
    end
  end

  // Request capture, wait-state counting, access and handshake completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_mfc   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MEMEn) begin
            r_addr <= addrIn;
            r_data <= dataIn;
            r_rd   <= MEMR_W;
            r_busy <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_ACCESS;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!MEMEn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (r_rd) begin
            r_dout <= r_mem[r_addr];
          end
          r_mfc   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // Release only after the initiator drops MEMEn; a held MEMEn never restarts.
          if (!MEMEn) begin
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mfc   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dataOut = r_dout;
  assign MFC     = r_mfc;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mem_mfc_responder.sv
// Self-checking bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_mem_mfc_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef struct {
    int               sel;
    logic [DATA_W-1:0] exp_dout;
    int               exp_lat;
  } sb_t;

  typedef struct {
    bit               rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              men  [2];
  logic              rw   [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] din  [2];
  logic [DATA_W-1:0] dout [2];
  logic              mfc  [2];
  logic              busy [2];

  int checks;
  int errors;
  sb_t sb_q[$];
  logic [DATA_W-1:0] last_rd [2];
  int waits [2];

  mem_mfc_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(rst_n), .MEMEn(men[0]), .MEMR_W(rw[0]), .addrIn(addr[0]),
    .dataIn(din[0]), .dataOut(dout[0]), .MFC(mfc[0]), .busy(busy[0]));

  mem_mfc_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .MEMEn(men[1]), .MEMR_W(rw[1]), .addrIn(addr[1]),
    .dataIn(din[1]), .dataOut(dout[1]), .MFC(mfc[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive a request on instance s; optionally push its expected completion.
  task automatic start(input int s, input bit rd, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit push, input logic [DATA_W-1:0] rd_val);
    sb_t e;
    men[s]  = 1'b1;
    rw[s]   = rd;
    addr[s] = a;
    din[s]  = d;
    if (push) begin
      if (rd) last_rd[s] = rd_val;
      e.sel      = s;
      e.exp_dout = last_rd[s];
      e.exp_lat  = waits[s] + 1;
      sb_q.push_back(e);
    end
  endtask

  // Count edges from capture until MFC, then pop and compare the scoreboard entry.
  task automatic wait_mfc(input int s, input int already);
    sb_t e;
    int  cnt;
    bit  seen;
    cnt  = already;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 1) chk("busy_after_capture", 32'(busy[s]), 32'd1);
      if (mfc[s]) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL mfc_timeout: got no MFC expected MFC within 40 edges");
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got MFC expected no pending transaction");
      return;
    end
    e = sb_q.pop_front();
    chk("sb_sel", 32'(s), 32'(e.sel));
    chk("mfc_latency", 32'(cnt - 1), 32'(e.exp_lat));
    chk("dataout", 32'(dout[s]), 32'(e.exp_dout));
    chk("busy_done", 32'(busy[s]), 32'd1);
  endtask

  task automatic release_req(input int s);
    men[s] = 1'b0;
    tick();
    chk("mfc_clear", 32'(mfc[s]), 32'd0);
    chk("busy_clear", 32'(busy[s]), 32'd0);
  endtask

  task automatic txn(input int s, input bit rd, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] rd_val);
    start(s, rd, a, d, 1'b1, rd_val);
    wait_mfc(s, 0);
    release_req(s);
  endtask

  vec_t vecs [10];

  initial begin
    checks = 0;
    errors = 0;
    waits[0] = 2;
    waits[1] = 0;
    for (int i = 0; i < 2; i++) begin
      men[i] = 1'b0; rw[i] = 1'b0; addr[i] = '0; din[i] = '0; last_rd[i] = '0;
    end

    vecs[0] = '{1'b0, 8'h12, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 8'h12, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b0, 8'h05, 16'h0A0A, 16'h0000};
    vecs[3] = '{1'b0, 8'h20, 16'h7777, 16'h0000};
    vecs[4] = '{1'b0, 8'h13, 16'h3333, 16'h0000};
    vecs[5] = '{1'b1, 8'h05, 16'h0000, 16'h0A0A};
    vecs[6] = '{1'b0, 8'hFF, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b1, 8'hFF, 16'h0000, 16'hFFFF};
    vecs[8] = '{1'b0, 8'h00, 16'h8001, 16'h0000};
    vecs[9] = '{1'b1, 8'h00, 16'h0000, 16'h8001};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_mfc", 32'(mfc[i]), 32'd0);
      chk("rst_dout", 32'(dout[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
    end

    // Table-driven transactions on the WAIT_CYCLES=2 instance
    for (int i = 0; i < 10; i++) begin
      txn(0, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
    end

    // Abort after one cycle in WAIT: no access, MFC stays low
    start(0, 1'b0, 8'h05, 16'h1234, 1'b0, '0);
    tick();
    tick();
    men[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_mfc", 32'(mfc[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
    end
    txn(0, 1'b1, 8'h05, '0, 16'h0A0A);

    // Reset mid-WAIT cancels the write and clears outputs
    start(0, 1'b0, 8'h20, 16'h5555, 1'b0, '0);
    tick();
    rst_n  = 1'b0;
    men[0] = 1'b0;
    tick();
    chk("midrst_mfc", 32'(mfc[0]), 32'd0);
    chk("midrst_dout", 32'(dout[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    tick();
    txn(0, 1'b1, 8'h20, '0, 16'h7777);

    // Inputs changed after capture do not affect the transaction
    start(0, 1'b0, 8'h12, 16'hC0DE, 1'b1, '0);
    tick();
    addr[0] = 8'h13;
    din[0]  = 16'h9999;
    rw[0]   = 1'b1;
    wait_mfc(0, 1);
    release_req(0);
    txn(0, 1'b1, 8'h12, '0, 16'hC0DE);
    txn(0, 1'b1, 8'h13, '0, 16'h3333);

    // Hold MEMEn in DONE: MFC held, no second transaction
    start(0, 1'b1, 8'h12, '0, 1'b1, 16'hC0DE);
    wait_mfc(0, 0);
    addr[0] = 8'h05;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_mfc", 32'(mfc[0]), 32'd1);
      chk("hold_busy", 32'(busy[0]), 32'd1);
      chk("hold_dout", 32'(dout[0]), 32'hC0DE);
    end
    release_req(0);
    tick();
    chk("no_restart_busy", 32'(busy[0]), 32'd0);
    chk("no_restart_dout", 32'(dout[0]), 32'hC0DE);

    // Zero wait states on the second instance
    txn(1, 1'b0, 8'h00, 16'h00A5, '0);
    txn(1, 1'b1, 8'h00, '0, 16'h00A5);
    txn(1, 1'b0, 8'hFF, 16'h5A5A, '0);
    txn(1, 1'b1, 8'hFF, '0, 16'h5A5A);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_mfc_responder.md
Name: mem_mfc_responder

Overview:
- Memory-side responder for the MEMEn / MEMR_W / MFC handshake driven by the load/store control FSM.
- Holds a synchronous word RAM. Captures the address (from MAR) and write data (from MDR) when MEMEn is asserted, inserts programmable wait states, performs the read or write, and raises MFC.
- Read data drives the MDR read-input path.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W words, so no address is out of range.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, wait states between capture and access; legal range 0..15.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- MEMEn  in  1  request from the initiator; 4-phase handshake.
- MEMR_W  in  1  1 = read (load), 0 = write (store); sampled only at capture.
- addrIn  in  ADDR_W  address from MAR; sampled only at capture.
- dataIn  in  DATA_W  write data from MDR; sampled only at capture.
- dataOut  out  DATA_W  registered read data.
- MFC  out  1  memory function complete; registered.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state becomes IDLE; MFC=0, dataOut=0, busy=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset overrides everything. If reset arrives mid-transaction before the ACCESS edge, no RAM write occurs.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On an edge with MEMEn=1, capture addrIn, dataIn and MEMR_W into internal registers (edge N).
  - If WAIT_CYCLES=0, go to ACCESS; otherwise load counter = WAIT_CYCLES-1 and go to WAIT.
  - With MEMEn=0, stay in IDLE.
- WAIT:
  - If MEMEn=0 at an edge: abort, go to IDLE, no RAM access, MFC stays 0.
  - Else if counter=0, go to ACCESS; else decrement the counter.
- ACCESS (one cycle): the edge leaving ACCESS performs the access, sets MFC<=1 and enters DONE.
  - Read: dataOut <= RAM[captured addr].
  - Write: RAM[captured addr] <= captured data; dataOut unchanged.
  - MEMEn is ignored in ACCESS; once ACCESS is entered the access always completes.
- DONE:
  - MFC is held at 1 while MEMEn=1.
  - The first edge with MEMEn=0 clears MFC and returns to IDLE.
  - A new request needs MEMEn low for at least one sampled edge; MEMEn held high in DONE never starts a second transaction.
- Latency: MFC is high from edge N+WAIT_CYCLES+1 (N = capture edge). Example: WAIT_CYCLES=2 gives MFC at N+3; WAIT_CYCLES=0 gives MFC at N+1.
- Changes to addrIn, dataIn or MEMR_W after capture have no effect on the transaction in flight.
- dataOut holds the most recent read value until the next completed read.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Write then read, WAIT_CYCLES=2:
  - Write 0xBEEF to addr 0x12 (MEMR_W=0) -> MFC rises exactly 3 edges after capture; dataOut remains 0.
  - Drop MEMEn -> MFC=0 on the next edge.
  - Read addr 0x12 (MEMR_W=1) -> dataOut=0xBEEF when MFC rises.
- Abort: assert MEMEn for a write of 0x1234 to addr 0x05, drop it after 1 cycle in WAIT -> MFC never rises; a subsequent read of 0x05 returns the prior contents.
- Hold in DONE: keep MEMEn=1 for 10 cycles after MFC -> MFC stays 1, no second access, busy=1. MEMEn=0 -> MFC and busy clear on the next edge.
- Zero wait, WAIT_CYCLES=0: read addr 0x00 previously written with 0x00A5 -> MFC and dataOut=0x00A5 at capture edge+1.
- Reset mid-WAIT: start a write of 0x5555 to addr 0x20, pull reset low while in WAIT -> MFC=0, dataOut=0, busy=0 next edge; a later read of 0x20 returns the old value.
- Input change after capture: change addrIn from 0x12 to 0x13 and dataIn during WAIT -> the write lands at 0x12 with the originally captured data; 0x13 is unchanged.
